// File: rtl/i2c_master.sv
`default_nettype none
// ============================================================================
// Module  : i2c_master
// Purpose : Single-transaction open-drain I2C master: START, address+R/W,
//           ACK check, one data byte (write or read, NACKed), STOP.
//           Optional SCL clock stretching: I2C_MASTER_CLOCK_STRETCH_EN.
// Rev     : 1.0  initial release
// ============================================================================
module i2c_master #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int I2C_FREQ_HZ = 100_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       ack_error,
    output logic [7:0] rdata,
    inout  wire        scl,
    inout  wire        sda
);

    localparam int QDIV = CLK_FREQ_HZ / (4 * I2C_FREQ_HZ);
    localparam int QW   = (QDIV < 2) ? 1 : $clog2(QDIV);
    localparam logic [QW-1:0] QMAX = QW'(QDIV - 1);

    generate
        if (QDIV < 2) begin : g_qdiv_check
            $fatal(1, "i2c_master: QDIV must be at least 2");
        end
    endgenerate

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_START     = 4'd1,
        S_ADDR      = 4'd2,
        S_ADDR_ACK  = 4'd3,
        S_WRITE     = 4'd4,
        S_WRITE_ACK = 4'd5,
        S_READ      = 4'd6,
        S_READ_NACK = 4'd7,
        S_STOP      = 4'd8,
        S_DONE      = 4'd9
    } state_t;

    state_t          r_state;
    logic [QW-1:0]   r_qcnt;
    logic [1:0]      r_quarter;
    logic [2:0]      r_bitcnt;
    logic [7:0]      r_tx;
    logic [7:0]      r_rx;
    logic [7:0]      r_wdata;
    logic            r_rw;
    logic [1:0]      r_sda_sync;
    logic [1:0]      r_samp;
    logic            r_scl_low;
    logic            r_sda_low;

    logic            w_active;
    logic            w_q2_start;
    logic            w_hold;
    logic            w_restart;
    logic            w_abort;
    logic            w_scl_low;
    logic            w_sda_low;

    assign scl = r_scl_low ? 1'b0 : 1'bz;
    assign sda = r_sda_low ? 1'b0 : 1'bz;

    assign w_active   = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_q2_start = w_active && (r_quarter == 2'd2) && (r_qcnt == '0);

`ifdef I2C_MASTER_CLOCK_STRETCH_EN
    logic [1:0]  r_scl_sync;
    logic [15:0] r_stretch_cnt;
    logic        w_q1_end;

    // A slave holding SCL low freezes the end of Q1; once released, Q1 reruns
    // in full so Q2 begins a full quarter after SCL is seen high.
    assign w_q1_end  = w_active && (r_quarter == 2'd1) && (r_qcnt == QMAX);
    assign w_hold    = w_q1_end && !r_scl_sync[1];
    assign w_abort   = w_hold && (r_stretch_cnt == 16'hFFFF);
    assign w_restart = w_q1_end && r_scl_sync[1] && (r_stretch_cnt != 16'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync    <= 2'b11;
            r_stretch_cnt <= 16'd0;
        end else begin
            r_scl_sync <= {r_scl_sync[0], scl};
            if (w_abort)
                r_stretch_cnt <= 16'd0;
            else if (w_hold)
                r_stretch_cnt <= r_stretch_cnt + 16'd1;
            else if (w_q1_end)
                r_stretch_cnt <= 16'd0;
        end
    end
`else
    assign w_hold    = 1'b0;
    assign w_restart = 1'b0;
    assign w_abort   = 1'b0;
`endif

    // Bus levels for the current state/quarter; registered one cycle later.
    always_comb begin
        w_scl_low = 1'b0;
        w_sda_low = 1'b0;
        case (r_state)
            S_START: begin
                w_sda_low = (r_quarter != 2'd0);
                w_scl_low = (r_quarter == 2'd3);
            end
            S_ADDR, S_WRITE: begin
                w_scl_low = (r_quarter == 2'd0) || (r_quarter == 2'd3);
                w_sda_low = !r_tx[7];
            end
            S_ADDR_ACK, S_WRITE_ACK, S_READ, S_READ_NACK: begin
                w_scl_low = (r_quarter == 2'd0) || (r_quarter == 2'd3);
            end
            S_STOP: begin
                w_scl_low = (r_quarter == 2'd0);
                w_sda_low = (r_quarter != 2'd3);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_qcnt     <= '0;
            r_quarter  <= 2'd0;
            r_bitcnt   <= 3'd0;
            r_tx       <= 8'd0;
            r_rx       <= 8'd0;
            r_wdata    <= 8'd0;
            r_rw       <= 1'b0;
            r_sda_sync <= 2'b11;
            r_samp     <= 2'b00;
            r_scl_low  <= 1'b0;
            r_sda_low  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ack_error  <= 1'b0;
            rdata      <= 8'd0;
        end else begin
            done       <= 1'b0;
            r_sda_sync <= {r_sda_sync[0], sda};
            r_samp     <= {r_samp[0], w_q2_start};
            r_scl_low  <= w_scl_low;
            r_sda_low  <= w_sda_low;

            // Sample two cycles into Q2, matching the synchronizer depth.
            if (r_samp[1]) begin
                if ((r_state == S_ADDR_ACK || r_state == S_WRITE_ACK) && r_sda_sync[1])
                    ack_error <= 1'b1;
                if (r_state == S_READ)
                    r_rx <= {r_rx[6:0], r_sda_sync[1]};
            end

            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_tx      <= {addr, rw};
                        r_rw      <= rw;
                        r_wdata   <= wdata;
                        r_rx      <= 8'd0;
                        ack_error <= 1'b0;
                        busy      <= 1'b1;
                        r_qcnt    <= '0;
                        r_quarter <= 2'd0;
                        r_state   <= S_START;
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: begin
                    if (w_abort) begin
                        ack_error <= 1'b1;
                        r_qcnt    <= '0;
                        r_quarter <= 2'd0;
                        r_state   <= S_STOP;
                    end else if (w_restart) begin
                        r_qcnt <= '0;
                    end else if (!w_hold) begin
                        if (r_qcnt != QMAX) begin
                            r_qcnt <= r_qcnt + 1'b1;
                        end else begin
                            r_qcnt    <= '0;
                            r_quarter <= r_quarter + 2'd1;
                            if (r_quarter == 2'd3) begin
                                case (r_state)
                                    S_START: begin
                                        r_bitcnt <= 3'd0;
                                        r_state  <= S_ADDR;
                                    end
                                    S_ADDR, S_WRITE: begin
                                        r_bitcnt <= r_bitcnt + 3'd1;
                                        r_tx     <= {r_tx[6:0], 1'b0};
                                        if (r_bitcnt == 3'd7)
                                            r_state <= (r_state == S_ADDR) ? S_ADDR_ACK : S_WRITE_ACK;
                                    end
                                    S_ADDR_ACK: begin
                                        r_bitcnt <= 3'd0;
                                        r_tx     <= r_wdata;
                                        if (ack_error)
                                            r_state <= S_STOP;
                                        else
                                            r_state <= r_rw ? S_READ : S_WRITE;
                                    end
                                    S_READ: begin
                                        r_bitcnt <= r_bitcnt + 3'd1;
                                        if (r_bitcnt == 3'd7)
                                            r_state <= S_READ_NACK;
                                    end
                                    S_WRITE_ACK, S_READ_NACK: r_state <= S_STOP;
                                    S_STOP: begin
                                        done    <= 1'b1;
                                        busy    <= 1'b0;
                                        rdata   <= r_rx;
                                        r_state <= S_DONE;
                                    end
                                    default: r_state <= S_IDLE;
                                endcase
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_i2c_master
// Purpose : Self-checking bench for i2c_master with an event-driven I2C slave
//           (LED register at 0x55) and bus monitor.
// Rev     : 1.0  initial release
// ============================================================================
module tb_i2c_master;

    localparam int QDIV = 4;
    localparam logic [6:0] SLAVE_ADDR = 7'h55;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic [6:0] addr = 7'd0;
    logic       rw = 1'b0;
    logic [7:0] wdata = 8'd0;
    logic       busy, done, ack_error;
    logic [7:0] rdata;
    wire        scl_w;
    wire        sda_w;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    pullup (scl_w);
    pullup (sda_w);

    i2c_master #(.CLK_FREQ_HZ(4_000_000), .I2C_FREQ_HZ(250_000)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .rw(rw), .wdata(wdata),
        .busy(busy), .done(done), .ack_error(ack_error), .rdata(rdata),
        .scl(scl_w), .sda(sda_w)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- slave model and bus monitor ----------------
    logic [7:0] sl_rdata = 8'h00;
    logic       sl_nack = 1'b0;
    logic       s_sda_low = 1'b0;
    logic [7:0] led = 8'h00;
    logic       prev_scl = 1'b1, prev_sda = 1'b1;
    logic       in_txn = 1'b0, matched = 1'b0, is_read = 1'b0;
    int         bitpos = 0, byte_idx = 0, mon_stops = 0;
    logic [7:0] shreg = 8'h00;
    logic [7:0] mon_bytes[$];
    logic       mon_acks[$];

    assign sda_w = s_sda_low ? 1'b0 : 1'bz;

    always @(scl_w or sda_w) begin
        if (scl_w !== prev_scl) begin
            if (scl_w === 1'b1 && in_txn) begin
                if (bitpos < 8) begin
                    shreg  = {shreg[6:0], sda_w};
                    bitpos = bitpos + 1;
                end else begin
                    mon_bytes.push_back(shreg);
                    mon_acks.push_back(sda_w);
                    bitpos   = 0;
                    byte_idx = byte_idx + 1;
                end
            end else if (scl_w === 1'b0 && in_txn) begin
                if (bitpos == 8) begin
                    if (byte_idx == 0) begin
                        matched   = (shreg[7:1] == SLAVE_ADDR);
                        is_read   = shreg[0];
                        s_sda_low = matched;
                    end else if (matched && !is_read && !sl_nack) begin
                        led       = shreg;
                        s_sda_low = 1'b1;
                    end else begin
                        s_sda_low = 1'b0;
                    end
                end else if (bitpos == 0 && byte_idx > 0) begin
                    s_sda_low = (byte_idx == 1 && matched && is_read) ? !sl_rdata[7] : 1'b0;
                end else if (matched && is_read && byte_idx == 1) begin
                    s_sda_low = !sl_rdata[3'(7 - bitpos)];
                end
            end
        end else if (sda_w !== prev_sda && scl_w === 1'b1) begin
            if (sda_w === 1'b0) begin
                in_txn = 1'b1; bitpos = 0; byte_idx = 0; matched = 1'b0; is_read = 1'b0;
                s_sda_low = 1'b0; mon_stops = 0;
                mon_bytes.delete(); mon_acks.delete();
            end else if (sda_w === 1'b1 && in_txn) begin
                in_txn    = 1'b0;
                mon_stops = mon_stops + 1;
            end
        end
        prev_scl = scl_w;
        prev_sda = sda_w;
    end

    // ---------------- checking ----------------
    typedef struct {
        logic [6:0] a;
        logic       r;
        logic [7:0] wd;
        logic [7:0] srd;
        logic       snack;
        logic       exp_err;
        logic [7:0] exp_rdata;
        int         exp_lat;
        int         nbytes;
        logic [7:0] b0;
        logic       k0;
        logic [7:0] b1;
        logic       k1;
        logic       chk_led;
        logic [7:0] exp_led;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected outcome from the protocol rules: only 0x55 answers; a full
    // transaction is 80 quarters, an address NACK 44; reads end with NACK.
    function automatic vec_t model(input logic [6:0] a, input logic r, input logic [7:0] wd,
                                   input logic [7:0] srd, input logic snack);
        vec_t v;
        bit hit = (a == SLAVE_ADDR);
        v.a = a; v.r = r; v.wd = wd; v.srd = srd; v.snack = snack;
        v.exp_err   = !hit || (!r && snack);
        v.exp_rdata = srd;
        v.exp_lat   = (hit ? 80 : 44) * QDIV + 1;
        v.nbytes    = hit ? 2 : 1;
        v.b0 = {a, r};  v.k0 = !hit;
        v.b1 = r ? srd : wd;
        v.k1 = r ? 1'b1 : snack;
        v.chk_led = hit && !r && !snack;
        v.exp_led = wd;
        return v;
    endfunction

    task automatic apply_vec(input vec_t v, input bit glitch);
        int k0;
        bit seen;
        sl_rdata = v.srd;
        sl_nack  = v.snack;
        @(negedge clk);
        req = 1'b1; addr = v.a; rw = v.r; wdata = v.wd;
        k0 = cyc;
        @(negedge clk);
        req = 1'b0; addr = 7'($urandom); rw = 1'($urandom); wdata = 8'($urandom);
        chk("busy_after_accept", busy, 1'b1);
        if (glitch) begin
            repeat (20) @(negedge clk);
            req = 1'b1; addr = 7'h12; rw = ~v.r; wdata = ~v.wd;
            @(negedge clk);
            req = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("done_seen", seen, 1'b1);
        if (seen) begin
            chk("latency", cyc - k0, v.exp_lat);
            chk("ack_error", ack_error, v.exp_err);
            chk("busy_at_done", busy, 1'b0);
            if (v.r && v.nbytes == 2) chk("rdata", rdata, v.exp_rdata);
            chk("stop_count", mon_stops, 1);
            chk("byte_count", mon_bytes.size(), v.nbytes);
            if (mon_bytes.size() >= 1) begin
                chk("addr_byte", mon_bytes[0], v.b0);
                chk("addr_ack", mon_acks[0], v.k0);
            end
            if (mon_bytes.size() >= 2 && v.nbytes == 2) begin
                chk("data_byte", mon_bytes[1], v.b1);
                chk("data_ack", mon_acks[1], v.k1);
            end
            if (v.chk_led) chk("led", led, v.exp_led);
            @(negedge clk);
            chk("done_pulse", done, 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[4];
        tbl[0] = '{7'h55, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0, 8'h00, 80*QDIV+1, 2, 8'hAA, 1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5};
        tbl[1] = '{7'h12, 1'b0, 8'h77, 8'h00, 1'b0, 1'b1, 8'h00, 44*QDIV+1, 1, 8'h24, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00};
        tbl[2] = '{7'h55, 1'b1, 8'h00, 8'h3C, 1'b0, 1'b0, 8'h3C, 80*QDIV+1, 2, 8'hAB, 1'b0, 8'h3C, 1'b1, 1'b0, 8'h00};
        tbl[3] = '{7'h55, 1'b0, 8'h5A, 8'h00, 1'b1, 1'b1, 8'h00, 80*QDIV+1, 2, 8'hAA, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h00};

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ack_error", ack_error, 1'b0);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_scl", scl_w, 1'b1);
        chk("rst_sda", sda_w, 1'b1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) apply_vec(tbl[i], i == 0);

        for (int i = 0; i < 8; i++) begin
            logic [6:0] a;
            vec_t v;
            if ($urandom_range(0, 1) == 1) begin
                a = SLAVE_ADDR;
            end else begin
                do a = 7'($urandom); while (a == SLAVE_ADDR);
            end
            v = model(a, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) == 0));
            apply_vec(v, $urandom_range(0, 1) == 1);
        end

        // Reset in the middle of the data byte, then a clean write.
        sl_nack = 1'b0;
        @(negedge clk);
        req = 1'b1; addr = SLAVE_ADDR; rw = 1'b0; wdata = 8'hC3;
        @(negedge clk);
        req = 1'b0;
        repeat (206) @(negedge clk);
        chk("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_scl", scl_w, 1'b1);
        chk("mid_rst_sda", sda_w, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        apply_vec(model(SLAVE_ADDR, 1'b0, 8'h0F, 8'h00, 1'b0), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
